div_iter: RTL and testbench
===========================

# div_iter

Iterative radix-2 restoring divider, parametrised in operand width, for the execute stage of the five-stage MIPS pipeline. EX issues DIV/DIVU operands with a start pulse and stalls while the unit is busy. The unit runs one quotient bit per cycle and applies a sign fix-up. On completion it presents quotient (for LO) and remainder (for HI) with a one-cycle done pulse. EX can cancel an in-flight operation on a pipeline flush.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a division; sampled only in IDLE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- dividend_i  in  WIDTH  dividend; sampled with start_i.
- divisor_i  in  WIDTH  divisor; sampled with start_i.
- cancel_i  in  1  abort the current operation (pipeline flush).
- busy_o  out  1  high in every state except IDLE; EX uses it as its stall request.
- done_o  out  1  one-cycle pulse; results valid in this cycle.
- quotient_o  out  WIDTH  quotient; held until the next done_o.
- remainder_o  out  WIDTH  remainder; held until the next done_o.
- dbz_o  out  1  divide-by-zero flag, valid with done_o; present only with DIV_ZERO_DETECT_EN.

## Operation
- States: IDLE, CALC, FIX, and DZ (DZ only with the macro).
- IDLE with start_i=1 and cancel_i=0:
  - Latch the operand magnitudes. When signed_i=1, negative operands are negated.
  - Latch the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Clear the iteration counter.
  - Go to CALC, or to DZ when the macro is on and divisor_i==0.
- start_i together with cancel_i in IDLE is ignored.
- CALC, per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtraction.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment the counter. After WIDTH iterations go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register the results into quotient_o and remainder_o, pulse done_o, and return to IDLE.
- DZ: load quotient_o=0, remainder_o=0, dbz_o=1, pulse done_o, and return to IDLE.
- cancel_i=1 in CALC, FIX or DZ: return to IDLE on the next edge with no done_o. quotient_o, remainder_o and dbz_o are left unchanged. Cancel has priority over completion in the same cycle.
- start_i while busy is ignored and is not queued.
- Arithmetic is modulo 2^WIDTH. Signed most-negative ÷ −1 gives quotient = most-negative and remainder 0, with no trap.
- dbz_o is cleared on every normal (non-zero-divisor) done.

## Timing
- Reset values: state IDLE, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, dbz_o=0, all internal registers 0.
- Reset mid-operation aborts immediately with no done_o.
- Start sampled at edge E0:
  - busy_o is high from E0 up to E(WIDTH+1).
  - done_o is high for the single cycle E(WIDTH+1)..E(WIDTH+2), with busy_o=0 in that cycle.
  - Latency is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- Divide-by-zero path (with the macro): done_o in cycle E1..E2; latency 1.
- Back-to-back operation: start_i may be asserted in the done_o cycle, because the state is already IDLE. No dead cycle between operations.
- done_o never asserts without a preceding accepted start.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - A zero divisor takes the DZ path (latency 1).
  - Result is quotient_o=0, remainder_o=0, and dbz_o=1 with done_o.
- DIV_ZERO_DETECT_EN undefined:
  - No DZ state and no dbz_o port.
  - A zero divisor runs the full CALC/FIX sequence with normal latency.
  - Unsigned result: quotient_o = all ones, remainder_o = dividend.
  - Signed result: the same algorithm's values after sign fix-up.

## Test plan
- Unsigned 100÷7 (WIDTH=32): start at E0 → done_o at E33, quotient_o=14, remainder_o=2, busy_o high for 33 cycles.
- Signed −7÷2 → quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF. Signed 0x80000000÷0xFFFFFFFF → quotient_o=0x80000000, remainder_o=0.
- Cancel:
  - Setup: complete 9÷4 (quotient_o=2, remainder_o=1), then start 50÷5 and assert cancel_i 10 cycles in.
  - Required: busy_o drops the next cycle, no done_o appears, and the outputs remain 2/1.
- Divide-by-zero with the macro: unsigned 5÷0 → done_o 1 cycle after start, quotient_o=0, remainder_o=0, dbz_o=1. Without the macro: done_o at 33 cycles, quotient_o=0xFFFFFFFF, remainder_o=5.
- Back-to-back: start 20÷3 and, in its done_o cycle (quotient_o=6, remainder_o=2), start 20÷6 → second done_o exactly 33 cycles later with quotient_o=3, remainder_o=2. A start_i asserted mid-operation is ignored.
- Async reset asserted mid-CALC → all outputs 0 immediately and no done_o. A fresh start after reset release completes normally.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// One quotient bit per cycle, then a sign fix-up cycle; results land in
// quotient_o (LO) and remainder_o (HI) with a single-cycle done_o pulse.
// Optional feature macro: DIV_ZERO_DETECT_EN adds the DZ state and dbz_o,
// giving a one-cycle zero-divisor result instead of running the full loop.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; results held
// CALC  | shift/trial-subtract, one quotient bit per edge, WIDTH edges
// FIX   | apply quotient/remainder sign fix-up, register results, done
// DZ    | zero divisor: load 0/0 with dbz_o=1, done (macro only)

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
`ifdef DIV_ZERO_DETECT_EN
  output logic             dbz_o,
`endif
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

`ifdef DIV_ZERO_DETECT_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, DZ} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
`endif

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;
`ifdef DIV_ZERO_DETECT_EN
  logic             dbz_q;
`endif

  logic             accept;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic             keep;

  // Operand magnitudes and the per-step trial subtraction.
  always_comb begin
    accept = start_i && !cancel_i;
    neg_a  = signed_i && dividend_i[WIDTH-1];
    neg_b  = signed_i && divisor_i[WIDTH-1];
    mag_a  = neg_a ? (~dividend_i + ONE) : dividend_i;
    mag_b  = neg_b ? (~divisor_i + ONE) : divisor_i;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    // remainder stays below the divisor, so bit WIDTH is the borrow
    keep   = ~diff[WIDTH];
  end

  // Next-state logic; cancel wins over completion in every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_DETECT_EN
          state_d = (divisor_i == '0) ? DZ : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (cancel_i)                state_d = IDLE;
        else if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX:     state_d = IDLE;
`ifdef DIV_ZERO_DETECT_EN
      DZ:      state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath: operand capture, iteration, fix-up and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem_q  <= '0;
            quo_q  <= mag_a;
            dvs_q  <= mag_b;
            qneg_q <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          if (!cancel_i) begin
            rem_q <= keep ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], keep};
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          if (!cancel_i) begin
            quotient_q  <= qneg_q ? (~quo_q + ONE) : quo_q;
            remainder_q <= rneg_q ? (~rem_q + ONE) : rem_q;
            done_q      <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q       <= 1'b0;
`endif
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        DZ: begin
          if (!cancel_i) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b1;
            done_q      <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
  assign dbz_o       = dbz_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Testbench for div_iter (WIDTH=32): behavioural reference model plus a
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_div_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         cancel_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         busy_o, done_o;
  logic [W-1:0] quotient_o, remainder_o;
  logic         dbz_o;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .cancel_i(cancel_i),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o),
`ifdef DIV_ZERO_DETECT_EN
    .dbz_o(dbz_o),
`endif
    .remainder_o(remainder_o)
  );
`ifndef DIV_ZERO_DETECT_EN
  assign dbz_o = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  // Reference results straight from integer arithmetic.
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t   t;
    longint sa, sb, lq, lr;
    t = '0;
    if (b == '0) begin
`ifdef DIV_ZERO_DETECT_EN
      t.dz = 1'b1;
`else
      // magnitude quotient by zero is all ones, remainder is the dividend
      // magnitude; the sign fix-up then turns a negative dividend's quotient into 1
      t.r = a;
      t.q = (s && a[W-1]) ? W'(1) : '1;
`endif
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      t.q = lq[W-1:0];
      t.r = lr[W-1:0];
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
      lq = sa / sb;
      lr = sa % sb;
      t.q = lq[W-1:0];
      t.r = lr[W-1:0];
    end
    return t;
  endfunction

  // Transaction-level model: accepted start -> result after a fixed latency.
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;
  res_t pend   = '0;
  res_t hold   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      hold   <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start_i && !cancel_i) begin
          m_busy <= 1'b1;
          pend   <= ref_div(dividend_i, divisor_i, signed_i);
`ifdef DIV_ZERO_DETECT_EN
          m_cnt  <= (divisor_i == '0) ? 1 : W + 1;
`else
          m_cnt  <= W + 1;
`endif
        end
      end else if (cancel_i) begin
        m_busy <= 1'b0;
      end else if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        hold   <= pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Every cycle: status and held results against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("quotient", quotient_o, hold.q);
      chk("remainder", remainder_o, hold.r);
`ifdef DIV_ZERO_DETECT_EN
      chk("dbz", dbz_o, hold.dz);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit inj, output logic [W-1:0] gq, output logic [W-1:0] gr);
    int lat, exp_lat;
    exp_lat = W + 1;
`ifdef DIV_ZERO_DETECT_EN
    if (b == '0) exp_lat = 1;
`endif
    dividend_i = a; divisor_i = b; signed_i = s; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    lat = 0;
    do begin
      if (inj && lat == 10) begin
        start_i = 1'b1; dividend_i = $urandom; divisor_i = W'(1);
      end
      tick;
      lat++;
      start_i = 1'b0;
    end while (!done_o && lat < 200);
    chk("latency", lat, exp_lat);
    gq = quotient_o;
    gr = remainder_o;
  endtask

  task automatic cancel_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int k);
    dividend_i = a; divisor_i = b | W'(1); signed_i = s; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (k) tick;
    cancel_i = 1'b1;
    tick;
    cancel_i = 1'b0;
    chk("cancel busy drop", busy_o, 1'b0);
    repeat (W + 4) tick;
  endtask

  logic [W-1:0] gq, gr, ra, rb;
  logic         rs;
  int           sel;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset busy", busy_o, 1'b0);
    chk("reset done", done_o, 1'b0);
    chk("reset quotient", quotient_o, 0);
    chk("reset remainder", remainder_o, 0);
    chk("reset dbz", dbz_o, 1'b0);
    tick;

    run_op(100, 7, 1'b0, 1'b0, gq, gr);
    chk("100/7 q", gq, 14);
    chk("100/7 r", gr, 2);
    chk("model 100/7 q", hold.q, 14);
    tick;

    run_op(-32'sd7, 2, 1'b1, 1'b0, gq, gr);
    chk("-7/2 q", gq, 32'hFFFF_FFFD);
    chk("-7/2 r", gr, 32'hFFFF_FFFF);
    chk("model -7/2 r", hold.r, 32'hFFFF_FFFF);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, gq, gr);
    chk("minneg/-1 q", gq, 32'h8000_0000);
    chk("minneg/-1 r", gr, 0);
    tick;

    // cancel ten cycles into 50/5 leaves 9/4 results in place
    run_op(9, 4, 1'b0, 1'b0, gq, gr);
    chk("9/4 q", gq, 2);
    chk("9/4 r", gr, 1);
    tick;
    cancel_op(50, 5, 1'b0, 9);
    chk("after cancel q", quotient_o, 2);
    chk("after cancel r", remainder_o, 1);

    // cancel landing in the fix-up cycle suppresses completion
    cancel_op(77, 3, 1'b0, W);
    chk("cancel in fix q", quotient_o, 2);

    run_op(5, 0, 1'b0, 1'b0, gq, gr);
`ifdef DIV_ZERO_DETECT_EN
    chk("5/0 q", gq, 0);
    chk("5/0 r", gr, 0);
    chk("5/0 dbz", dbz_o, 1'b1);
`else
    chk("5/0 q", gq, 32'hFFFF_FFFF);
    chk("5/0 r", gr, 5);
`endif
    tick;

    // back-to-back: second start in the first done cycle, start mid-op ignored
    run_op(20, 3, 1'b0, 1'b0, gq, gr);
    chk("20/3 q", gq, 6);
    chk("20/3 r", gr, 2);
    run_op(20, 6, 1'b0, 1'b1, gq, gr);
    chk("20/6 q", gq, 3);
    chk("20/6 r", gr, 2);
`ifdef DIV_ZERO_DETECT_EN
    chk("dbz cleared", dbz_o, 1'b0);
`endif
    tick;

    // start with cancel in IDLE is ignored
    start_i = 1'b1; cancel_i = 1'b1; dividend_i = 40; divisor_i = 4;
    tick;
    start_i = 1'b0; cancel_i = 1'b0;
    chk("start+cancel ignored", busy_o, 1'b0);
    tick;

    // async reset mid-CALC
    dividend_i = 1000; divisor_i = 3; signed_i = 1'b0; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (5) tick;
    #2 rst = 1'b0;
    #1;
    chk("mid reset busy", busy_o, 1'b0);
    chk("mid reset done", done_o, 1'b0);
    chk("mid reset q", quotient_o, 0);
    chk("mid reset r", remainder_o, 0);
    repeat (2) tick;
    #2 rst = 1'b1;
    tick;
    run_op(1000, 3, 1'b0, 1'b0, gq, gr);
    chk("post reset q", gq, 333);
    chk("post reset r", gr, 1);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      case (sel)
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h8000_0000;
        3: rb = W'($urandom_range(1, 50));
        4: ra = W'($urandom_range(0, 1000));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0)
        cancel_op(ra, rb, rs, $urandom_range(1, W));
      else
        run_op(ra, rb, rs, ($urandom_range(0, 3) == 0), gq, gr);
      if ($urandom_range(0, 1) == 0) tick;
    end

    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
